cm_event_sink: RTL and testbench

Receive-side counterpart of the Config Manager output interface. It samples the CM output bundle (status, config notification, error and VGA notification streams), turns each valid pulse or status change into a typed event record, and queues the records in a FIFO. A host/scoreboard-side consumer drains the queue over a valid/ready port. It sits directly on the CM output pins, in place of the bench monitor in the integrated system.

---
 rtl/cm_event_sink_pkg.sv | 38 +++
 rtl/cm_event_sink_fifo.sv | 50 +++++
 rtl/cm_event_sink.sv | 161 ++++++++++++++++
 tb/tb_cm_event_sink.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cm_event_sink_pkg.sv
// cm_event_sink_pkg
//   Shared types and constants for the Config Manager event sink.
//   - Default widths of the CM output bundle fields.
//   - Event type encoding and the packed event record layout
//     {type[1:0], code[CODE_W-1:0], data[DATA_WIDTH-1:0]}.
package cm_event_sink_pkg;

    localparam int unsigned CONFIG_STATUS_WIDTH_DEF       = 4;
    localparam int unsigned CONFIG_NOTIFICATION_WIDTH_DEF = 4;
    localparam int unsigned CONFIG_ERROR_WIDTH_DEF        = 4;
    localparam int unsigned VGA_NOTIFICATION_WIDTH_DEF    = 4;
    localparam int unsigned DATA_WIDTH_DEF                = 8;

    function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int unsigned CODE_W  = max3(CONFIG_NOTIFICATION_WIDTH_DEF,
                                           CONFIG_ERROR_WIDTH_DEF,
                                           VGA_NOTIFICATION_WIDTH_DEF);
    localparam int unsigned EVENT_W = 2 + CODE_W + DATA_WIDTH_DEF;

    typedef enum logic [1:0] {
        EV_STATUS    = 2'b00,
        EV_CFG_NOTIF = 2'b01,
        EV_ERROR     = 2'b10,
        EV_VGA_NOTIF = 2'b11
    } ev_type_e;

    typedef struct packed {
        ev_type_e                  ev_type;
        logic [CODE_W-1:0]         code;
        logic [DATA_WIDTH_DEF-1:0] data;
    } ev_rec_t;

endpackage

// File: rtl/cm_event_sink_fifo.sv
// cm_event_fifo
//   Synchronous show-ahead FIFO. dout presents the head entry whenever
//   empty=0 and reads as zero when empty.
//   Ports: clk, rst_n (async, active-low), push/din, pop/dout,
//          full, empty, level (occupancy, 0..DEPTH).
module cm_event_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB on each pointer separates full from empty.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cm_event_sink.sv
// cm_event_sink
//   Samples the Config Manager output bundle, converts status changes and
//   valid pulses into typed event records, and queues them for a consumer.
//   Ports:
//     clk, rst_n                     clock, async active-low reset
//     Config_Status                  level, change raises STATUS
//     Config_Notification(_Valid)    CFG_NOTIF source
//     Config_Error / Error_Valid     ERROR source
//     VGA_Notification(_Valid), Data_VGA  VGA_NOTIF source (+ data)
//     ev_valid/ev_ready/ev_data      show-ahead event output
//     ev_level                       queue occupancy
//     drop_cnt / drop_clr            saturating lost-event count, sync clear
module cm_event_sink
    import cm_event_sink_pkg::*;
#(
    parameter int unsigned CONFIG_STATUS_WIDTH       = CONFIG_STATUS_WIDTH_DEF,
    parameter int unsigned CONFIG_NOTIFICATION_WIDTH = CONFIG_NOTIFICATION_WIDTH_DEF,
    parameter int unsigned CONFIG_ERROR_WIDTH        = CONFIG_ERROR_WIDTH_DEF,
    parameter int unsigned VGA_NOTIFICATION_WIDTH    = VGA_NOTIFICATION_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH                = DATA_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH                = 8,
    localparam int unsigned CW    = max3(CONFIG_NOTIFICATION_WIDTH, CONFIG_ERROR_WIDTH,
                                         VGA_NOTIFICATION_WIDTH),
    localparam int unsigned EW    = 2 + CW + DATA_WIDTH,
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [CONFIG_STATUS_WIDTH-1:0]       Config_Status,
    input  logic [CONFIG_NOTIFICATION_WIDTH-1:0] Config_Notification,
    input  logic                                 Config_Notification_Valid,
    input  logic [CONFIG_ERROR_WIDTH-1:0]        Config_Error,
    input  logic                                 Error_Valid,
    input  logic [VGA_NOTIFICATION_WIDTH-1:0]    VGA_Notification,
    input  logic                                 VGA_Notification_Valid,
    input  logic [DATA_WIDTH-1:0]                Data_VGA,
    output logic                                 ev_valid,
    input  logic                                 ev_ready,
    output logic [EW-1:0]                        ev_data,
    output logic [LVL_W-1:0]                     ev_level,
    output logic [7:0]                           drop_cnt,
    input  logic                                 drop_clr
);

    logic [CONFIG_STATUS_WIDTH-1:0] status_base;
    logic                           baseline_ok;
    logic                           status_chg;

    // Per-source vectors are indexed by the event type encoding.
    logic [3:0]            new_ev;
    logic [3:0]            pend;
    logic [3:0]            grant;
    logic [3:0]            load;
    logic [3:0]            drop;
    logic [CW-1:0]         new_code  [4];
    logic [CW-1:0]         pend_code [4];
    logic [DATA_WIDTH-1:0] pend_data;

    logic          fifo_full;
    logic          fifo_empty;
    logic [EW-1:0] wr_rec;
    logic [1:0]    wr_type;
    logic [CW-1:0] wr_code;
    logic [2:0]    n_drop;
    logic [8:0]    drop_sum;

    assign status_chg = baseline_ok && (Config_Status != status_base);

    assign new_ev = {VGA_Notification_Valid, Error_Valid, Config_Notification_Valid, status_chg};

    assign new_code[EV_STATUS]    = CW'(Config_Status);
    assign new_code[EV_CFG_NOTIF] = CW'(Config_Notification);
    assign new_code[EV_ERROR]     = CW'(Config_Error);
    assign new_code[EV_VGA_NOTIF] = CW'(VGA_Notification);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_base <= '0;
            baseline_ok <= 1'b0;
        end else if (!baseline_ok || status_chg) begin
            status_base <= Config_Status;
            baseline_ok <= 1'b1;
        end
    end

    // One write per cycle: ERROR > STATUS > CFG_NOTIF > VGA_NOTIF.
    always_comb begin
        grant = '0;
        if (!fifo_full) begin
            if      (pend[EV_ERROR])     grant[EV_ERROR]     = 1'b1;
            else if (pend[EV_STATUS])    grant[EV_STATUS]    = 1'b1;
            else if (pend[EV_CFG_NOTIF]) grant[EV_CFG_NOTIF] = 1'b1;
            else if (pend[EV_VGA_NOTIF]) grant[EV_VGA_NOTIF] = 1'b1;
        end
    end

    // An entry drained this cycle can accept a new event without loss.
    assign load = new_ev & (~pend | grant);
    assign drop = new_ev & pend & ~grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= '0;
            pend_data <= '0;
            for (int unsigned i = 0; i < 4; i++) pend_code[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (load[i]) begin
                    pend[i]      <= 1'b1;
                    pend_code[i] <= new_code[i];
                end else if (grant[i]) begin
                    pend[i] <= 1'b0;
                end
            end
            if (load[EV_VGA_NOTIF]) pend_data <= Data_VGA;
        end
    end

    always_comb begin
        wr_type = '0;
        wr_code = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (grant[i]) begin
                wr_type = 2'(i);
                wr_code = pend_code[i];
            end
        end
        wr_rec = {wr_type, wr_code, grant[EV_VGA_NOTIF] ? pend_data : {DATA_WIDTH{1'b0}}};
    end

    always_comb begin
        n_drop = '0;
        for (int unsigned i = 0; i < 4; i++) n_drop = n_drop + 3'(drop[i]);
        drop_sum = {1'b0, drop_cnt} + 9'(n_drop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             drop_cnt <= '0;
        else if (drop_clr)      drop_cnt <= '0;
        else if (drop_sum[8])   drop_cnt <= '1;
        else                    drop_cnt <= drop_sum[7:0];
    end

    cm_event_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (|grant),
        .din   (wr_rec),
        .pop   (ev_ready),
        .dout  (ev_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (ev_level)
    );

    assign ev_valid = !fifo_empty;

endmodule

// File: tb/tb_cm_event_sink.sv
module tb_cm_event_sink;
    import cm_event_sink_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [3:0]          Config_Status;
    logic [3:0]          Config_Notification;
    logic                Config_Notification_Valid;
    logic [3:0]          Config_Error;
    logic                Error_Valid;
    logic [3:0]          VGA_Notification;
    logic                VGA_Notification_Valid;
    logic [7:0]          Data_VGA;
    logic                ev_valid;
    logic                ev_ready;
    logic [EVENT_W-1:0]  ev_data;
    logic [3:0]          ev_level;
    logic [7:0]          drop_cnt;
    logic                drop_clr;

    int checks = 0;
    int errors = 0;
    logic [EVENT_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    cm_event_sink dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .Config_Status             (Config_Status),
        .Config_Notification       (Config_Notification),
        .Config_Notification_Valid (Config_Notification_Valid),
        .Config_Error              (Config_Error),
        .Error_Valid               (Error_Valid),
        .VGA_Notification          (VGA_Notification),
        .VGA_Notification_Valid    (VGA_Notification_Valid),
        .Data_VGA                  (Data_VGA),
        .ev_valid                  (ev_valid),
        .ev_ready                  (ev_ready),
        .ev_data                   (ev_data),
        .ev_level                  (ev_level),
        .drop_cnt                  (drop_cnt),
        .drop_clr                  (drop_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [EVENT_W-1:0] rec(input logic [1:0] t, input logic [3:0] c,
                                               input logic [7:0] d);
        return {t, c, d};
    endfunction

    // Monitor: a transfer happens on the next edge when valid & ready.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ev_valid === 1'b1 && ev_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ev_unexpected: got %0h expected none", ev_data);
            end else begin
                check("ev_data", 32'(ev_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        Config_Status = 4'h3;
        Config_Notification = '0; Config_Notification_Valid = 1'b0;
        Config_Error = '0;        Error_Valid = 1'b0;
        VGA_Notification = '0;    VGA_Notification_Valid = 1'b0;
        Data_VGA = '0; ev_ready = 1'b0; drop_clr = 1'b0;
        tick(2);
        check("rst_ev_valid", 32'(ev_valid), 0);
        check("rst_ev_level", 32'(ev_level), 0);
        check("rst_ev_data",  32'(ev_data),  0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);

        // Constant status: baseline load only, no events.
        rst_n = 1'b1;
        tick(10);
        check("idle_level", 32'(ev_level), 0);
        check("idle_valid", 32'(ev_valid), 0);
        check("idle_drop",  32'(drop_cnt), 0);

        // Single error with latency check.
        ev_ready = 1'b1;
        Config_Error = 4'h5; Error_Valid = 1'b1;
        exp_q.push_back(rec(2'b10, 4'h5, 8'h00));
        tick();
        Error_Valid = 1'b0;
        check("err_lat_n",   32'(ev_valid), 0);
        tick();
        check("err_lat_n1",  32'(ev_valid), 1);
        check("err_level1",  32'(ev_level), 1);
        tick();
        check("err_level0",  32'(ev_level), 0);

        // Three sources at once: priority order.
        Config_Error = 4'h6; Error_Valid = 1'b1;
        Config_Notification = 4'h1; Config_Notification_Valid = 1'b1;
        VGA_Notification = 4'h2; Data_VGA = 8'hA5; VGA_Notification_Valid = 1'b1;
        exp_q.push_back(rec(2'b10, 4'h6, 8'h00));
        exp_q.push_back(rec(2'b01, 4'h1, 8'h00));
        exp_q.push_back(rec(2'b11, 4'h2, 8'hA5));
        tick();
        Error_Valid = 1'b0; Config_Notification_Valid = 1'b0; VGA_Notification_Valid = 1'b0;
        tick(6);
        check("tri_level", 32'(ev_level), 0);
        check("tri_drop",  32'(drop_cnt), 0);

        // Fill the FIFO, hold one pending, drop one.
        ev_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            VGA_Notification = 4'(i); Data_VGA = 8'(8'h10 + i); VGA_Notification_Valid = 1'b1;
            exp_q.push_back(rec(2'b11, 4'(i), 8'(8'h10 + i)));
            tick();
            VGA_Notification_Valid = 1'b0;
            tick();
        end
        check("full_level", 32'(ev_level), 8);
        VGA_Notification = 4'hE; Data_VGA = 8'hEE; VGA_Notification_Valid = 1'b1;
        tick();
        VGA_Notification_Valid = 1'b0;
        tick();
        check("full_drop",   32'(drop_cnt), 1);
        check("full_level2", 32'(ev_level), 8);
        ev_ready = 1'b1;
        tick(14);
        check("drain_level", 32'(ev_level), 0);
        check("drain_valid", 32'(ev_valid), 0);

        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        check("clr_drop", 32'(drop_cnt), 0);

        // Back-to-back VGA while ERROR pending.
        Config_Error = 4'h7; Error_Valid = 1'b1;
        VGA_Notification = 4'h3; Data_VGA = 8'h33; VGA_Notification_Valid = 1'b1;
        exp_q.push_back(rec(2'b10, 4'h7, 8'h00));
        exp_q.push_back(rec(2'b11, 4'h3, 8'h33));
        tick();
        Error_Valid = 1'b0;
        VGA_Notification = 4'h4; Data_VGA = 8'h44;
        tick();
        VGA_Notification_Valid = 1'b0;
        check("b2b_drop", 32'(drop_cnt), 1);
        tick(5);

        // drop_clr coinciding with a new drop wins.
        Config_Error = 4'h8; Error_Valid = 1'b1;
        VGA_Notification = 4'h5; Data_VGA = 8'h55; VGA_Notification_Valid = 1'b1;
        exp_q.push_back(rec(2'b10, 4'h8, 8'h00));
        exp_q.push_back(rec(2'b11, 4'h5, 8'h55));
        tick();
        Error_Valid = 1'b0;
        VGA_Notification = 4'h6; Data_VGA = 8'h66; drop_clr = 1'b1;
        tick();
        VGA_Notification_Valid = 1'b0; drop_clr = 1'b0;
        check("clr_prio_drop", 32'(drop_cnt), 0);
        tick(5);
        check("b2b_level", 32'(ev_level), 0);

        // Status change 3 -> 7.
        Config_Status = 4'h7;
        exp_q.push_back(rec(2'b00, 4'h7, 8'h00));
        tick(5);
        check("status_level", 32'(ev_level), 0);

        // Async reset with 4 entries queued.
        ev_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            Config_Error = 4'(i + 1); Error_Valid = 1'b1;
            tick();
            Error_Valid = 1'b0;
            tick();
        end
        tick();
        check("pre_rst_level", 32'(ev_level), 4);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(ev_valid), 0);
        check("async_rst_level", 32'(ev_level), 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("post_rst_valid", 32'(ev_valid), 0);
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
